// File: rtl/memory_pkg.sv
// Shared types and helpers for the MEM stage: access sizes, the
// misalignment rule and load-lane extraction with sign/zero extension.
package memory_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } access_size_t;

  // A size code of 3 behaves like WORD everywhere.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr);
    logic mis;
    case (size)
      BYTE:    mis = 1'b0;
      HALF:    mis = addr[0];
      default: mis = (addr != 2'b00);
    endcase
    return mis;
  endfunction

  // Picks the addressed little-endian lane out of a memory word and widens
  // it to 32 bits; WORD loads ignore zero_ext.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  addr,
                                               input logic        zero_ext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (addr)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = addr[1] ? word[31:16] : word[15:0];
    case (size)
      BYTE:    r = zero_ext ? {24'h000000, b} : {{24{b[7]}}, b};
      HALF:    r = zero_ext ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/memory_access_stage_if.sv
// EX/MEM-side inputs and MEM/WB-side outputs of the memory access stage.
// The master drives the instruction (upstream pipeline), the slave is the stage.
interface memory_access_stage_if;
  import memory_pkg::*;

  logic        valid_in;
  logic        mem_to_reg_in;
  logic        reg_write_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [1:0]  size_in;
  logic        unsigned_in;
  logic [31:0] alu_result_in;
  logic [31:0] write_data_in;
  logic [4:0]  reg_write_addr_in;

  logic        stall_out;
  logic        valid_out;
  logic        mem_to_reg_out;
  logic        reg_write_out;
  logic [31:0] read_data_out;
  logic [31:0] alu_result_out;
  logic [4:0]  reg_write_addr_out;
  logic        misaligned_out;

  modport master (
    output valid_in, mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in,
           size_in, unsigned_in, alu_result_in, write_data_in, reg_write_addr_in,
    input  stall_out, valid_out, mem_to_reg_out, reg_write_out, read_data_out,
           alu_result_out, reg_write_addr_out, misaligned_out
  );

  modport slave (
    input  valid_in, mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in,
           size_in, unsigned_in, alu_result_in, write_data_in, reg_write_addr_in,
    output stall_out, valid_out, mem_to_reg_out, reg_write_out, read_data_out,
           alu_result_out, reg_write_addr_out, misaligned_out
  );

endinterface

// File: rtl/data_memory_banked.sv
// Data memory built from four byte-wide banks so partial stores only touch
// the lanes they address. Reads are combinational; contents are never reset.
module data_memory_banked #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic [3:0]               we,
  input  logic [$clog2(DEPTH)-1:0] index,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  for (genvar k = 0; k < 4; k++) begin : g_bank
    logic [7:0] bank [DEPTH];

    // Each bank owns one byte lane and writes only when its enable is set
    always_ff @(posedge clk) begin
      if (we[k]) bank[index] <= wdata[8*k +: 8];
    end

    assign rdata[8*k +: 8] = bank[index];
  end

endmodule

// File: rtl/memory_access_stage.sv
// MEM stage: owns the data memory, performs sized loads/stores, flags
// misaligned accesses, emulates wait states and registers the MEM/WB outputs.
module memory_access_stage
  import memory_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic                  clk,
  input logic                  reset,
  memory_access_stage_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic          mem_op;
  logic          mis;
  logic          stall;
  logic          do_access;
  logic [AW-1:0] index;
  logic [3:0]    lane_we;
  logic [31:0]   store_word;
  logic [31:0]   mem_word;
  logic [31:0]   load_value;

  assign index  = bus.alu_result_in[AW+1:2];
  assign mem_op = bus.valid_in & (bus.mem_read_in | bus.mem_write_in);
  assign mis    = mem_op & is_misaligned(bus.size_in, bus.alu_result_in[1:0]);

  if (WAIT_STATES == 0) begin : g_no_wait
    assign stall = 1'b0;
  end else begin : g_wait
    localparam int CW = $clog2(WAIT_STATES + 1);
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // Wait-state counter: zero means idle, non-zero means an access is in flight
    always_ff @(posedge clk) begin
      if (!reset) cnt <= '0;
      else        cnt <= cnt_next;
    end

    // Stall until the counter reaches the wait count; a dropped valid_in or
    // reset clears it. Nothing stalls while reset is held.
    always_comb begin
      stall    = 1'b0;
      cnt_next = '0;
      if (reset && mem_op && !mis && (cnt != CW'(WAIT_STATES))) begin
        stall    = 1'b1;
        cnt_next = cnt + 1'b1;
      end
    end
  end

  assign bus.stall_out = stall;

  // Reset blocks the access so a store caught mid-wait never commits
  assign do_access = reset & mem_op & ~mis & ~stall;

  // Replicate store data across lanes and enable only the addressed ones
  always_comb begin
    lane_we    = 4'b0000;
    store_word = bus.write_data_in;
    case (bus.size_in)
      BYTE:    store_word = {4{bus.write_data_in[7:0]}};
      HALF:    store_word = {2{bus.write_data_in[15:0]}};
      default: store_word = bus.write_data_in;
    endcase
    if (do_access && bus.mem_write_in) begin
      case (bus.size_in)
        BYTE:    lane_we = 4'b0001 << bus.alu_result_in[1:0];
        HALF:    lane_we = bus.alu_result_in[1] ? 4'b1100 : 4'b0011;
        default: lane_we = 4'b1111;
      endcase
    end
  end

  data_memory_banked #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (lane_we),
    .index (index),
    .wdata (store_word),
    .rdata (mem_word)
  );

  assign load_value = extract_load(mem_word, bus.size_in, bus.alu_result_in[1:0],
                                   bus.unsigned_in);

  // MEM/WB register: clears on reset, loads a bubble while stalled
  always_ff @(posedge clk) begin
    if (!reset || stall) begin
      bus.valid_out          <= 1'b0;
      bus.mem_to_reg_out     <= 1'b0;
      bus.reg_write_out      <= 1'b0;
      bus.read_data_out      <= '0;
      bus.alu_result_out     <= '0;
      bus.reg_write_addr_out <= '0;
      bus.misaligned_out     <= 1'b0;
    end else begin
      bus.valid_out          <= bus.valid_in;
      bus.mem_to_reg_out     <= bus.valid_in & bus.mem_to_reg_in;
      bus.reg_write_out      <= bus.valid_in & bus.reg_write_in & ~mis;
      bus.read_data_out      <= (mem_op && bus.mem_read_in && !mis) ? load_value : '0;
      bus.alu_result_out     <= bus.alu_result_in;
      bus.reg_write_addr_out <= bus.reg_write_addr_in;
      bus.misaligned_out     <= mis;
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: one fast instance (no wait states, 1024 words)
// and one slow instance (two wait states, 16 words) sharing clock and reset.
module tb_memory_access_stage;
  import memory_pkg::*;

  typedef struct {
    logic        valid;
    logic        rd;
    logic        wr;
    logic        rw;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_mis;
    logic        exp_rw;
    logic        chk_rd;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passes = 0;

  logic [7:0] ref_mem [0:4095];

  always #5 clk = ~clk;

  memory_access_stage_if bus_fast ();
  memory_access_stage_if bus_slow ();

  memory_access_stage #(.DEPTH(1024), .WAIT_STATES(0)) dut_fast (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_fast)
  );

  memory_access_stage #(.DEPTH(16), .WAIT_STATES(2)) dut_slow (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_slow)
  );

  function automatic vec_t mk(input logic valid, input logic rd, input logic wr,
                              input logic rw, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rd, input logic exp_mis,
                              input logic exp_rw, input logic chk_rd);
    vec_t v;
    v.valid = valid; v.rd = rd; v.wr = wr; v.rw = rw; v.size = size; v.uns = uns;
    v.addr = addr; v.wdata = wdata; v.exp_rd = exp_rd; v.exp_mis = exp_mis;
    v.exp_rw = exp_rw; v.chk_rd = chk_rd;
    return v;
  endfunction

  function automatic int accessBytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic refMis(input logic [31:0] addr, input logic [1:0] size);
    int n = accessBytes(size);
    return (n > 1) && ((int'(addr[1:0]) % n) != 0);
  endfunction

  function automatic logic [31:0] refLoad(input logic [31:0] addr, input logic [1:0] size,
                                          input logic uns);
    int n = accessBytes(size);
    int a = int'(addr[11:0]);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++) v = v + (32'(ref_mem[a+i]) << (8*i));
    if (n < 4 && !uns && v[8*n-1]) v = v - (32'd1 << (8*n));
    return v;
  endfunction

  task automatic refStore(input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wdata);
    int n = accessBytes(size);
    int a = int'(addr[11:0]);
    for (int i = 0; i < n; i++) ref_mem[a+i] = wdata[8*i +: 8];
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic applyStimulus(input bit slow, input vec_t v, input logic [4:0] ra);
    if (slow) begin
      bus_slow.valid_in = v.valid; bus_slow.mem_read_in = v.rd; bus_slow.mem_write_in = v.wr;
      bus_slow.reg_write_in = v.rw; bus_slow.mem_to_reg_in = v.rd; bus_slow.size_in = v.size;
      bus_slow.unsigned_in = v.uns; bus_slow.alu_result_in = v.addr;
      bus_slow.write_data_in = v.wdata; bus_slow.reg_write_addr_in = ra;
    end else begin
      bus_fast.valid_in = v.valid; bus_fast.mem_read_in = v.rd; bus_fast.mem_write_in = v.wr;
      bus_fast.reg_write_in = v.rw; bus_fast.mem_to_reg_in = v.rd; bus_fast.size_in = v.size;
      bus_fast.unsigned_in = v.uns; bus_fast.alu_result_in = v.addr;
      bus_fast.write_data_in = v.wdata; bus_fast.reg_write_addr_in = ra;
    end
  endtask

  task automatic fastStep(input vec_t v, input logic [4:0] ra, input string tag);
    @(negedge clk);
    applyStimulus(1'b0, v, ra);
    #4;
    checkOutput({tag, " stall"}, 32'(bus_fast.stall_out), 32'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, " valid"}, 32'(bus_fast.valid_out), 32'(v.valid));
    checkOutput({tag, " reg_write"}, 32'(bus_fast.reg_write_out), 32'(v.exp_rw));
    checkOutput({tag, " misaligned"}, 32'(bus_fast.misaligned_out), 32'(v.exp_mis));
    if (v.chk_rd) checkOutput({tag, " read_data"}, bus_fast.read_data_out, v.exp_rd);
    if (v.valid) begin
      checkOutput({tag, " alu_result"}, bus_fast.alu_result_out, v.addr);
      checkOutput({tag, " rd_addr"}, 32'(bus_fast.reg_write_addr_out), 32'(ra));
      checkOutput({tag, " mem_to_reg"}, 32'(bus_fast.mem_to_reg_out), 32'(v.rd));
    end
  endtask

  task automatic slowOp(input vec_t v, input string tag);
    int stalls = 0;
    bit done = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1, v, 5'd9);
    for (int c = 0; c < 8 && !done; c++) begin
      #4;
      if (bus_slow.stall_out) stalls++;
      else done = 1'b1;
      @(posedge clk);
      #1;
      if (!done) begin
        checkOutput({tag, " bubble valid"}, 32'(bus_slow.valid_out), 32'd0);
        checkOutput({tag, " bubble reg_write"}, 32'(bus_slow.reg_write_out), 32'd0);
        @(negedge clk);
      end
    end
    checkOutput({tag, " completed"}, 32'(done), 32'd1);
    checkOutput({tag, " stall cycles"}, 32'(stalls), 32'd2);
    checkOutput({tag, " valid"}, 32'(bus_slow.valid_out), 32'd1);
    checkOutput({tag, " reg_write"}, 32'(bus_slow.reg_write_out), 32'(v.exp_rw));
    if (v.chk_rd) checkOutput({tag, " read_data"}, bus_slow.read_data_out, v.exp_rd);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " fast valid"}, 32'(bus_fast.valid_out), 32'd0);
    checkOutput({tag, " fast mem_to_reg"}, 32'(bus_fast.mem_to_reg_out), 32'd0);
    checkOutput({tag, " fast reg_write"}, 32'(bus_fast.reg_write_out), 32'd0);
    checkOutput({tag, " fast read_data"}, bus_fast.read_data_out, 32'd0);
    checkOutput({tag, " fast alu_result"}, bus_fast.alu_result_out, 32'd0);
    checkOutput({tag, " fast rd_addr"}, 32'(bus_fast.reg_write_addr_out), 32'd0);
    checkOutput({tag, " fast misaligned"}, 32'(bus_fast.misaligned_out), 32'd0);
    checkOutput({tag, " fast stall"}, 32'(bus_fast.stall_out), 32'd0);
    checkOutput({tag, " slow valid"}, 32'(bus_slow.valid_out), 32'd0);
    checkOutput({tag, " slow mem_to_reg"}, 32'(bus_slow.mem_to_reg_out), 32'd0);
    checkOutput({tag, " slow reg_write"}, 32'(bus_slow.reg_write_out), 32'd0);
    checkOutput({tag, " slow read_data"}, bus_slow.read_data_out, 32'd0);
    checkOutput({tag, " slow alu_result"}, bus_slow.alu_result_out, 32'd0);
    checkOutput({tag, " slow rd_addr"}, 32'(bus_slow.reg_write_addr_out), 32'd0);
    checkOutput({tag, " slow misaligned"}, 32'(bus_slow.misaligned_out), 32'd0);
    checkOutput({tag, " slow stall"}, 32'(bus_slow.stall_out), 32'd0);
  endtask

  function automatic vec_t randomVec();
    vec_t v;
    v.valid = ($urandom_range(0, 1) == 1);
    v.rd = 1'($urandom); v.wr = 1'($urandom); v.rw = 1'($urandom);
    v.size = 2'($urandom); v.uns = 1'($urandom);
    v.addr = $urandom; v.wdata = $urandom;
    v.exp_rd = 32'd0; v.exp_mis = 1'b0; v.exp_rw = 1'b0; v.chk_rd = 1'b0;
    return v;
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t table_v [14];
    vec_t idle;
    vec_t v;

    idle = mk(0, 0, 0, 0, 2'd2, 0, 32'd0, 32'd0, 32'd0, 0, 0, 0);

    // Reset with random inputs on both instances
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      applyStimulus(1'b0, randomVec(), 5'($urandom));
      applyStimulus(1'b1, randomVec(), 5'($urandom));
      @(posedge clk);
    end
    #1;
    checkAllZero("reset");
    @(negedge clk);
    applyStimulus(1'b0, idle, 5'd0);
    applyStimulus(1'b1, idle, 5'd0);
    reset = 1'b1;

    // Preload fast memory bytes 0..255 with random words
    for (int w = 0; w < 64; w++) begin
      v = mk(1, 0, 1, 0, 2'd2, 0, 32'(w * 4), $urandom, 32'd0, 0, 0, 0);
      refStore(v.addr, v.size, v.wdata);
      fastStep(v, 5'd0, "preload");
    end

    // Random traffic against the byte-array reference model
    for (int i = 0; i < 150; i++) begin
      int kind = $urandom_range(0, 3);
      logic memop;
      v.valid  = ($urandom_range(0, 7) != 0);
      v.rd     = (kind == 1 || kind == 2);
      v.wr     = (kind == 3);
      v.rw     = v.rd ? 1'b1 : (kind == 0) ? 1'($urandom) : 1'b0;
      v.size   = 2'($urandom);
      v.uns    = 1'($urandom);
      v.addr   = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
      v.wdata  = $urandom;
      memop    = v.valid && (v.rd || v.wr);
      v.exp_mis = memop && refMis(v.addr, v.size);
      v.exp_rw = v.valid && v.rw && !v.exp_mis;
      v.exp_rd = (memop && v.rd && !v.exp_mis) ? refLoad(v.addr, v.size, v.uns) : 32'd0;
      v.chk_rd = v.valid && !(v.wr && !v.rd && !v.exp_mis);
      if (memop && v.wr && !v.exp_mis) refStore(v.addr, v.size, v.wdata);
      fastStep(v, 5'($urandom), "random");
    end

    // Directed back-to-back vectors on the fast instance
    table_v[0]  = mk(1, 0, 1, 0, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'd0, 0, 0, 0);
    table_v[1]  = mk(1, 1, 0, 1, 2'd2, 0, 32'h10, 32'd0, 32'hDEADBEEF, 0, 1, 1);
    table_v[2]  = mk(1, 0, 1, 0, 2'd0, 0, 32'h13, 32'h00000080, 32'd0, 0, 0, 0);
    table_v[3]  = mk(1, 1, 0, 1, 2'd0, 0, 32'h13, 32'd0, 32'hFFFFFF80, 0, 1, 1);
    table_v[4]  = mk(1, 1, 0, 1, 2'd0, 1, 32'h13, 32'd0, 32'h00000080, 0, 1, 1);
    table_v[5]  = mk(1, 1, 0, 1, 2'd2, 0, 32'h10, 32'd0, 32'h80ADBEEF, 0, 1, 1);
    table_v[6]  = mk(1, 1, 0, 1, 2'd1, 1, 32'h12, 32'd0, 32'h000080AD, 0, 1, 1);
    table_v[7]  = mk(1, 0, 1, 0, 2'd1, 0, 32'h11, 32'h00001234, 32'd0, 1, 0, 1);
    table_v[8]  = mk(1, 1, 0, 1, 2'd2, 0, 32'h10, 32'd0, 32'h80ADBEEF, 0, 1, 1);
    table_v[9]  = mk(1, 1, 0, 1, 2'd1, 0, 32'h12, 32'd0, 32'hFFFF80AD, 0, 1, 1);
    table_v[10] = mk(1, 1, 0, 1, 2'd0, 0, 32'h10, 32'd0, 32'hFFFFFFEF, 0, 1, 1);
    table_v[11] = mk(1, 0, 0, 1, 2'd3, 0, 32'h1234, 32'd0, 32'd0, 0, 1, 1);
    table_v[12] = mk(1, 1, 0, 1, 2'd2, 0, 32'h12, 32'd0, 32'd0, 1, 0, 1);
    table_v[13] = mk(1, 1, 0, 1, 2'd0, 1, 32'h11, 32'd0, 32'h000000BE, 0, 1, 1);
    for (int i = 0; i < 14; i++) fastStep(table_v[i], 5'(i + 1), $sformatf("table[%0d]", i));
    @(negedge clk);
    applyStimulus(1'b0, idle, 5'd0);

    // Slow instance: wait states, reset during a pending store, cancel, wrap
    slowOp(mk(1, 0, 1, 0, 2'd2, 0, 32'h08, 32'hCAFEF00D, 32'd0, 0, 0, 0), "slow sw");
    slowOp(mk(1, 1, 0, 1, 2'd2, 0, 32'h08, 32'd0, 32'hCAFEF00D, 0, 1, 1), "slow lw");

    @(negedge clk);
    applyStimulus(1'b1, mk(1, 0, 1, 0, 2'd2, 0, 32'h08, 32'h11111111, 32'd0, 0, 0, 0), 5'd0);
    #4;
    checkOutput("wait-reset stall", 32'(bus_slow.stall_out), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("wait-reset valid", 32'(bus_slow.valid_out), 32'd0);
    checkOutput("wait-reset stall in reset", 32'(bus_slow.stall_out), 32'd0);
    @(negedge clk);
    applyStimulus(1'b1, idle, 5'd0);
    reset = 1'b1;
    slowOp(mk(1, 1, 0, 1, 2'd2, 0, 32'h08, 32'd0, 32'hCAFEF00D, 0, 1, 1), "after reset lw");

    @(negedge clk);
    applyStimulus(1'b1, mk(1, 0, 1, 0, 2'd2, 0, 32'h08, 32'hAAAAAAAA, 32'd0, 0, 0, 0), 5'd0);
    @(negedge clk);
    applyStimulus(1'b1, idle, 5'd0);
    @(posedge clk);
    #1;
    checkOutput("cancel valid", 32'(bus_slow.valid_out), 32'd0);
    slowOp(mk(1, 1, 0, 1, 2'd2, 0, 32'h08, 32'd0, 32'hCAFEF00D, 0, 1, 1), "after cancel lw");

    slowOp(mk(1, 0, 1, 0, 2'd2, 0, 32'h40, 32'h12345678, 32'd0, 0, 0, 0), "wrap sw");
    slowOp(mk(1, 1, 0, 1, 2'd2, 0, 32'h00, 32'd0, 32'h12345678, 0, 1, 1), "wrap lw");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
